demux_pair_rx: RTL and testbench

- Receive-side counterpart of the team's 2:1 select mux.
- Takes one time-multiplexed word stream `m` with its select tag `s`, and routes each word back to channel `x` (s=0) or channel `y` (s=1) holding registers.
- Tracks x/y pairing with a small FSM: flags completed pairs, counts them, and reports out-of-order (duplicate-channel) words.
- Sits at the far end of a serial/TDM link, downstream of the mux stage.

---
 rtl/demux_pair_rx.sv | 132 +++++++++++++
 tb/tb_demux_pair_rx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/demux_pair_rx.sv
// rtl/demux_pair_rx.sv - TDM word demux to x/y channels with pair tracking (optional DEMUX_PAIR_TIMEOUT_EN)
module demux_pair_rx #(
    parameter int WIDTH   = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v,
    input  logic [WIDTH-1:0] m,
    input  logic             s,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             x_stb,
    output logic             y_stb,
    output logic             pair_valid,
    output logic             err,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_X = 2'd1,
        HAVE_Y = 2'd2
    } state_t;

    state_t state;
    state_t state_eff;
    state_t state_nxt;
    logic   pair_nxt;
    logic   err_nxt;
    logic   tmo;

    // A timeout of zero would abandon every half-pair immediately
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

`ifdef DEMUX_PAIR_TIMEOUT_EN
    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;

    // A half-pair that has waited TIMEOUT idle edges is abandoned on this edge
    assign tmo = (state != IDLE) && (tcnt == TMAX);

    // Idle-edge counter: runs only while a half-pair is pending, any word clears it
    always_comb begin
        tcnt_nxt = '0;
        if (!v && state_eff != IDLE) begin
            tcnt_nxt = tcnt + 1'b1;
        end
    end

    // Idle-edge counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_nxt;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Pairing FSM: a timed-out half is dropped first so a word on that edge starts a new pair
    always_comb begin
        state_eff = tmo ? IDLE : state;
        state_nxt = state_eff;
        pair_nxt  = 1'b0;
        err_nxt   = tmo;
        if (v) begin
            case (state_eff)
                IDLE: begin
                    state_nxt = s ? HAVE_Y : HAVE_X;
                end
                HAVE_X: begin
                    if (s) begin
                        state_nxt = IDLE;
                        pair_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                HAVE_Y: begin
                    if (!s) begin
                        state_nxt = IDLE;
                        pair_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Channel routing, strobes, pair/error pulses and pair counter, all registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            x_stb      <= 1'b0;
            y_stb      <= 1'b0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
            pair_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            x_stb      <= v && !s;
            y_stb      <= v && s;
            pair_valid <= pair_nxt;
            err        <= err_nxt;
            if (v && !s) begin
                x <= m;
            end
            if (v && s) begin
                y <= m;
            end
            if (pair_nxt) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_pair_rx.sv
// tb/tb_demux_pair_rx.sv - self-checking bench for demux_pair_rx
module tb_demux_pair_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v = 1'b0;
    logic [1:0] m = 2'b00;
    logic       s = 1'b0;
    logic [1:0] x;
    logic [1:0] y;
    logic       x_stb;
    logic       y_stb;
    logic       pair_valid;
    logic       err;
    logic [1:0] pair_cnt;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic       xs;
        logic       ys;
        logic       pv;
        logic       er;
        logic [1:0] cnt;
    } out_t;

    typedef struct {
        logic       v;
        logic       s;
        logic [1:0] m;
        out_t       e;
    } vec_t;

    out_t sb[$];
    vec_t tbl[14];
    int   total = 0;
    int   passed = 0;

    demux_pair_rx #(.WIDTH(2), .CNT_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .v(v), .m(m), .s(s),
        .x(x), .y(y), .x_stb(x_stb), .y_stb(y_stb),
        .pair_valid(pair_valid), .err(err), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic out_t o(input logic [1:0] ex, input logic [1:0] ey, input logic exs,
                               input logic eys, input logic epv, input logic eer, input logic [1:0] ec);
        out_t r;
        r.x = ex; r.y = ey; r.xs = exs; r.ys = eys; r.pv = epv; r.er = eer; r.cnt = ec;
        return r;
    endfunction

    task automatic check(input string nm);
        out_t got;
        out_t exp;
        got = {x, y, x_stb, y_stb, pair_valid, err, pair_cnt};
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %b expected a queued record", nm, got);
            return;
        end
        exp = sb.pop_front();
        if (got == exp) passed++;
        else $display("FAIL %s: got x=%b y=%b xs=%b ys=%b pv=%b err=%b cnt=%0d expected x=%b y=%b xs=%b ys=%b pv=%b err=%b cnt=%0d",
                      nm, got.x, got.y, got.xs, got.ys, got.pv, got.er, got.cnt,
                      exp.x, exp.y, exp.xs, exp.ys, exp.pv, exp.er, exp.cnt);
        total++;
        if (!(err && pair_valid)) passed++;
        else $display("FAIL %s_excl: got err=1 pair_valid=1 expected never both", nm);
    endtask

    task automatic step(input logic vv, input logic ss, input logic [1:0] mm, input out_t e, input string nm);
        v = vv; s = ss; m = mm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    initial begin
        // main table: ordered pair, reverse pair with gap, duplicate channel, counter wrap
        tbl[0]  = '{1'b1, 1'b0, 2'b10, o(2'b10, 2'b00, 1, 0, 0, 0, 2'd0)};
        tbl[1]  = '{1'b1, 1'b1, 2'b01, o(2'b10, 2'b01, 0, 1, 1, 0, 2'd1)};
        tbl[2]  = '{1'b1, 1'b1, 2'b11, o(2'b10, 2'b11, 0, 1, 0, 0, 2'd1)};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, o(2'b10, 2'b11, 0, 0, 0, 0, 2'd1)};
        tbl[4]  = '{1'b0, 1'b1, 2'b01, o(2'b10, 2'b11, 0, 0, 0, 0, 2'd1)};
        tbl[5]  = '{1'b0, 1'b0, 2'b10, o(2'b10, 2'b11, 0, 0, 0, 0, 2'd1)};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, o(2'b00, 2'b11, 1, 0, 1, 0, 2'd2)};
        tbl[7]  = '{1'b1, 1'b0, 2'b01, o(2'b01, 2'b11, 1, 0, 0, 0, 2'd2)};
        tbl[8]  = '{1'b1, 1'b0, 2'b10, o(2'b10, 2'b11, 1, 0, 0, 1, 2'd2)};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, o(2'b10, 2'b11, 0, 1, 1, 0, 2'd3)};
        tbl[10] = '{1'b1, 1'b0, 2'b01, o(2'b01, 2'b11, 1, 0, 0, 0, 2'd3)};
        tbl[11] = '{1'b1, 1'b1, 2'b00, o(2'b01, 2'b00, 0, 1, 1, 0, 2'd0)};
        tbl[12] = '{1'b1, 1'b1, 2'b10, o(2'b01, 2'b10, 0, 1, 0, 0, 2'd0)};
        tbl[13] = '{1'b1, 1'b0, 2'b11, o(2'b11, 2'b10, 1, 0, 1, 0, 2'd1)};

        // reset held for 3 cycles, then 10 idle cycles: everything stays zero
        for (int i = 0; i < 3; i++) begin
            sb.push_back(o(2'b00, 2'b00, 0, 0, 0, 0, 2'd0));
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b11, o(2'b00, 2'b00, 0, 0, 0, 0, 2'd0), "idle");

        for (int i = 0; i < 14; i++) step(tbl[i].v, tbl[i].s, tbl[i].m, tbl[i].e, $sformatf("vec%0d", i));

        // first half of a 6th pair, then reset between the halves
        step(1'b1, 1'b0, 2'b10, o(2'b10, 2'b10, 1, 0, 0, 0, 2'd1), "half6");
        v = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(o(2'b00, 2'b00, 0, 0, 0, 0, 2'd0));
        check("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b1, 2'b01, o(2'b00, 2'b01, 0, 1, 0, 0, 2'd0), "after_reset_no_pair");

        // clean start for the timeout scenario
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 2'b01, o(2'b01, 2'b00, 1, 0, 0, 0, 2'd0), "tmo_x");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b00, o(2'b01, 2'b00, 0, 0, 0, 0, 2'd0), "tmo_wait");
`ifdef DEMUX_PAIR_TIMEOUT_EN
        step(1'b0, 1'b0, 2'b00, o(2'b01, 2'b00, 0, 0, 0, 1, 2'd0), "tmo_fire");
        step(1'b1, 1'b1, 2'b10, o(2'b01, 2'b10, 0, 1, 0, 0, 2'd0), "tmo_new_y");
        step(1'b1, 1'b0, 2'b11, o(2'b11, 2'b10, 1, 0, 1, 0, 2'd1), "tmo_pair_yx");
`else
        step(1'b0, 1'b0, 2'b00, o(2'b01, 2'b00, 0, 0, 0, 0, 2'd0), "no_tmo_wait");
        step(1'b1, 1'b1, 2'b10, o(2'b01, 2'b10, 0, 1, 1, 0, 2'd1), "no_tmo_pair");
        step(1'b1, 1'b0, 2'b11, o(2'b11, 2'b10, 1, 0, 0, 0, 2'd1), "no_tmo_new_x");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
